// File: rtl/alu_div_5bit_signed.sv
// Multi-cycle signed divider: restoring shift-and-subtract on operand magnitudes,
// one quotient bit per cycle, followed by a sign-correction cycle.
module alu_div_5bit_signed #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             DivByZero,
    output logic             Overflow
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    count_reg, count_next;
    logic [WIDTH-1:0] dvd_reg, dvd_next;     // |A|, shifted out MSB first; fills with quotient bits
    logic [WIDTH-1:0] dvs_reg, dvs_next;     // |B|
    logic [WIDTH:0]   prem_reg, prem_next;   // partial remainder
    logic             sign_q_reg, sign_q_next;
    logic             sign_r_reg, sign_r_next;
    logic [WIDTH-1:0] quot_reg, quot_next;
    logic [WIDTH-1:0] rem_reg, rem_next;
    logic             dz_reg, dz_next;
    logic             ov_reg, ov_next;

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+2:0] trial;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            count_reg  <= '0;
            dvd_reg    <= '0;
            dvs_reg    <= '0;
            prem_reg   <= '0;
            sign_q_reg <= 1'b0;
            sign_r_reg <= 1'b0;
            quot_reg   <= '0;
            rem_reg    <= '0;
            dz_reg     <= 1'b0;
            ov_reg     <= 1'b0;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            dvd_reg    <= dvd_next;
            dvs_reg    <= dvs_next;
            prem_reg   <= prem_next;
            sign_q_reg <= sign_q_next;
            sign_r_reg <= sign_r_next;
            quot_reg   <= quot_next;
            rem_reg    <= rem_next;
            dz_reg     <= dz_next;
            ov_reg     <= ov_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        dvd_next    = dvd_reg;
        dvs_next    = dvs_reg;
        prem_next   = prem_reg;
        sign_q_next = sign_q_reg;
        sign_r_next = sign_r_reg;
        quot_next   = quot_reg;
        rem_next    = rem_reg;
        dz_next     = dz_reg;
        ov_next     = ov_reg;

        // Trial subtraction with one spare MSB so its sign tells keep vs. restore.
        shifted = {prem_reg, dvd_reg[WIDTH-1]};
        trial   = {1'b0, shifted} - {3'b000, dvs_reg};

        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    sign_q_next = A[WIDTH-1] ^ B[WIDTH-1];
                    sign_r_next = A[WIDTH-1];
                    dz_next     = 1'b0;
                    ov_next     = 1'b0;
                    if (B == '0) begin
                        dz_next    = 1'b1;
                        quot_next  = '1;
                        rem_next   = A;
                        state_next = DONE;
                    end else if (A == MOST_NEG && B == '1) begin
                        ov_next    = 1'b1;
                        quot_next  = MOST_NEG;
                        rem_next   = '0;
                        state_next = DONE;
                    end else begin
                        // |MOST_NEG| still fits as an unsigned WIDTH-bit value.
                        dvd_next   = A[WIDTH-1] ? -A : A;
                        dvs_next   = B[WIDTH-1] ? -B : B;
                        prem_next  = '0;
                        count_next = '0;
                        state_next = CALC;
                    end
                end
            end
            CALC: begin
                dvd_next   = {dvd_reg[WIDTH-2:0], ~trial[WIDTH+2]};
                prem_next  = trial[WIDTH+2] ? shifted[WIDTH:0] : trial[WIDTH:0];
                count_next = count_reg + 1'b1;
                if (count_reg == CW'(WIDTH - 1)) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                quot_next  = sign_q_reg ? -dvd_reg : dvd_reg;
                rem_next   = sign_r_reg ? -prem_reg[WIDTH-1:0] : prem_reg[WIDTH-1:0];
                state_next = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign Quotient  = quot_reg;
    assign Remainder = rem_reg;
    assign DivByZero = dz_reg;
    assign Overflow  = ov_reg;

endmodule

// File: tb/tb_alu_div_5bit_signed.sv
// Directed and exhaustive checks of the 5-bit signed divider against hand values
// and a truncating-division reference.
module tb_alu_div_5bit_signed;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] A;
    logic [4:0] B;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] Quotient;
    logic [4:0] Remainder;
    logic       DivByZero;
    logic       Overflow;

    int assert_count = 0;
    int fail_count   = 0;

    alu_div_5bit_signed #(.WIDTH(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .DivByZero (DivByZero),
        .Overflow  (Overflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        assert_count++;
        if (got !== exp) begin
            fail_count++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Waits for in_ready, issues one operation, waits for the result, checks it,
    // then completes the output handshake.
    task automatic run_op(input string tag, input logic [4:0] a, input logic [4:0] b,
                          input logic [4:0] eq, input logic [4:0] er,
                          input logic edz, input logic eov,
                          output logic [4:0] gq, output logic [4:0] gr);
        int lat;
        int elat;
        elat = (edz || eov) ? 0 : 6;
        lat = 0;
        while (!in_ready && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        check_eq({tag, " in_ready"}, int'(in_ready), 1);
        A = a; B = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        A = 5'($urandom); B = 5'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        gq = Quotient; gr = Remainder;
        check_eq({tag, " latency"}, lat, elat);
        check_eq({tag, " out_valid"}, int'(out_valid), 1);
        check_eq({tag, " quotient"}, int'(Quotient), int'(eq));
        check_eq({tag, " remainder"}, int'(Remainder), int'(er));
        check_eq({tag, " divbyzero"}, int'(DivByZero), int'(edz));
        check_eq({tag, " overflow"}, int'(Overflow), int'(eov));
        $display("%s: A=%b B=%b -> Q=%b R=%b dz=%0d ov=%0d lat=%0d",
                 tag, a, b, Quotient, Remainder, DivByZero, Overflow, lat);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq({tag, " drop out_valid"}, int'(out_valid), 0);
        check_eq({tag, " in_ready after"}, int'(in_ready), 1);
    endtask

    initial begin
        logic [4:0] gq, gr;
        int lat;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0;
        #12;
        check_eq("reset in_ready", int'(in_ready), 1);
        check_eq("reset out_valid", int'(out_valid), 0);
        check_eq("reset quotient", int'(Quotient), 0);
        check_eq("reset remainder", int'(Remainder), 0);
        check_eq("reset divbyzero", int'(DivByZero), 0);
        check_eq("reset overflow", int'(Overflow), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op("7/2",   5'b00111, 5'b00010, 5'b00011, 5'b00001, 1'b0, 1'b0, gq, gr);
        run_op("-7/2",  5'b11001, 5'b00010, 5'b11101, 5'b11111, 1'b0, 1'b0, gq, gr);
        run_op("7/-2",  5'b00111, 5'b11110, 5'b11101, 5'b00001, 1'b0, 1'b0, gq, gr);
        run_op("-16/3", 5'b10000, 5'b00011, 5'b11011, 5'b11111, 1'b0, 1'b0, gq, gr);
        run_op("5/0",   5'b00101, 5'b00000, 5'b11111, 5'b00101, 1'b1, 1'b0, gq, gr);
        run_op("-16/-1", 5'b10000, 5'b11111, 5'b10000, 5'b00000, 1'b0, 1'b1, gq, gr);
        run_op("-16/1", 5'b10000, 5'b00001, 5'b10000, 5'b00000, 1'b0, 1'b0, gq, gr);

        // Backpressure: 13/3 = 4 r 1 held while a competing request is offered.
        A = 5'd13; B = 5'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        check_eq("bp latency", lat, 6);
        A = 5'd1; B = 5'd1; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check_eq("bp hold out_valid", int'(out_valid), 1);
            check_eq("bp hold in_ready", int'(in_ready), 0);
            check_eq("bp hold quotient", int'(Quotient), 4);
            check_eq("bp hold remainder", int'(Remainder), 1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq("bp release out_valid", int'(out_valid), 0);
        check_eq("bp release in_ready", int'(in_ready), 1);
        in_valid = 1'b0;
        $display("backpressure: 13/3 held 4 cycles, Q=%0d R=%0d", Quotient, Remainder);
        run_op("after bp -7/2", 5'b11001, 5'b00010, 5'b11101, 5'b11111, 1'b0, 1'b0, gq, gr);

        // Asynchronous reset in the middle of CALC (count=2).
        A = 5'd9; B = 5'd4; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check_eq("midrst in_ready", int'(in_ready), 1);
        check_eq("midrst out_valid", int'(out_valid), 0);
        check_eq("midrst quotient", int'(Quotient), 0);
        check_eq("midrst remainder", int'(Remainder), 0);
        check_eq("midrst flags", int'({DivByZero, Overflow}), 0);
        #9 rst = 1'b0;
        $display("mid-CALC reset applied during 9/4");
        @(posedge clk); #1;
        run_op("post-rst 7/2", 5'b00111, 5'b00010, 5'b00011, 5'b00001, 1'b0, 1'b0, gq, gr);

        // Exhaustive sweep against C-style truncating division.
        for (int ia = -16; ia < 16; ia++) begin
            for (int ib = -16; ib < 16; ib++) begin
                int eq_i, er_i, gq_i, gr_i;
                logic edz, eov;
                edz = (ib == 0);
                eov = (ia == -16 && ib == -1);
                if (edz) begin
                    eq_i = -1; er_i = ia;
                end else if (eov) begin
                    eq_i = -16; er_i = 0;
                end else begin
                    eq_i = ia / ib; er_i = ia % ib;
                end
                run_op("sweep", 5'(ia), 5'(ib), 5'(eq_i), 5'(er_i), edz, eov, gq, gr);
                if (ib != 0) begin
                    gq_i = $signed(gq);
                    gr_i = $signed(gr);
                    check_eq("sweep identity", (gq_i * ib + gr_i) & 31, ia & 31);
                    check_eq("sweep rem bound",
                             int'((gr_i < 0 ? -gr_i : gr_i) < (ib < 0 ? -ib : ib)), 1);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end
endmodule
